// File: rtl/wb_port_if.sv
// Completion-side and writeback-side signals of the shared register-file write port.
// The arbiter connects through the slave modport and the environment through the master modport.
interface wb_port_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned PHYS_W    = 6,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0]        unit_done;
    logic [NUM_UNITS*ID_W-1:0]   unit_id;
    logic [NUM_UNITS*PHYS_W-1:0] unit_phys_rd;
    logic [NUM_UNITS*DATA_W-1:0] unit_rd;
    logic [NUM_UNITS-1:0]        unit_ack;
    logic                        wb_valid;
    logic                        wb_ready;
    logic [ID_W-1:0]             wb_id;
    logic [PHYS_W-1:0]           wb_phys_addr;
    logic [DATA_W-1:0]           wb_data;
    logic [UW-1:0]               wb_unit;

    modport slave (
        input  unit_done, unit_id, unit_phys_rd, unit_rd, wb_ready,
        output unit_ack, wb_valid, wb_id, wb_phys_addr, wb_data, wb_unit
    );

    modport master (
        output unit_done, unit_id, unit_phys_rd, unit_rd, wb_ready,
        input  unit_ack, wb_valid, wb_id, wb_phys_addr, wb_data, wb_unit
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_UNITS execution units.
// The winner is registered into a single-entry valid/ready stage that reloads without bubbles.
module wb_port_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned PHYS_W    = 6,
    parameter int unsigned DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_port_if.slave    bus,
    output logic [15:0] busy_cycles
);
    localparam int unsigned UW    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned SCN_W = UW + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    stage_e               state_q;
    stage_e               state_d;
    logic [UW-1:0]        rr_ptr;
    logic [UW-1:0]        winner;
    logic [UW-1:0]        next_ptr;
    logic [SCN_W-1:0]     scan;
    logic                 found;
    logic                 can_load;
    logic                 grant;
    logic [NUM_UNITS-1:0] ack;
    logic [ID_W-1:0]      sel_id;
    logic [PHYS_W-1:0]    sel_phys;
    logic [DATA_W-1:0]    sel_data;
    logic [ID_W-1:0]      id_q;
    logic [PHYS_W-1:0]    phys_q;
    logic [DATA_W-1:0]    data_q;
    logic [UW-1:0]        unit_q;

    // Scan upward from rr_ptr with wrap; first requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            scan = {1'b0, rr_ptr} + SCN_W'(k);
            if (scan >= SCN_W'(NUM_UNITS)) begin
                scan = scan - SCN_W'(NUM_UNITS);
            end
            if (!found && bus.unit_done[scan[UW-1:0]]) begin
                found  = 1'b1;
                winner = scan[UW-1:0];
            end
        end
    end

    always_comb begin
        sel_id   = '0;
        sel_phys = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            if (winner == UW'(k)) begin
                sel_id   = bus.unit_id[k*ID_W +: ID_W];
                sel_phys = bus.unit_phys_rd[k*PHYS_W +: PHYS_W];
                sel_data = bus.unit_rd[k*DATA_W +: DATA_W];
            end
        end
    end

    assign can_load = (state_q == ST_EMPTY) | bus.wb_ready;
    assign grant    = can_load & found & ~rst;
    assign next_ptr = (winner == UW'(NUM_UNITS - 1)) ? '0 : winner + UW'(1);

    always_comb begin
        ack = '0;
        if (grant) begin
            ack[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A grant always (re)fills the stage; an accepted result with no grant empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL:  if (!grant && bus.wb_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q   <= '0;
            phys_q <= '0;
            data_q <= '0;
            unit_q <= '0;
            rr_ptr <= '0;
        end else if (grant) begin
            id_q   <= sel_id;
            phys_q <= sel_phys;
            data_q <= sel_data;
            unit_q <= winner;
            rr_ptr <= next_ptr;
        end
    end

    // Requests blocked by a stalled stage; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (found && !can_load && (busy_cycles != {CNT_W{1'b1}})) begin
            busy_cycles <= busy_cycles + CNT_W'(1);
        end
    end

    assign bus.unit_ack     = ack;
    assign bus.wb_valid     = (state_q == ST_FULL);
    assign bus.wb_id        = id_q;
    assign bus.wb_phys_addr = phys_q;
    assign bus.wb_data      = data_q;
    assign bus.wb_unit      = unit_q;
endmodule
